// File: rtl/mem_stage_sequencer.sv
// MEM-stage access sequencer for the LC-3b pipeline: one or two data-memory accesses per op.
// Optional stall-cycle counter enabled by defining MEM_STALL_CNT_EN.
module mem_stage_sequencer #(
    parameter int STALL_CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        is_ldi,
    input  logic        is_sti,
    input  logic        is_ldb_stb,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    input  logic        stall_other,
    input  logic        dmem_resp,
    input  logic [15:0] dmem_rdata,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    output logic [1:0]  dmem_byte_enable,
    output logic [15:0] load_data,
    output logic        mem_done,
`ifdef MEM_STALL_CNT_EN
    input  logic        stall_cnt_clr,
    output logic [STALL_CNT_W-1:0] stall_cycles,
`endif
    output logic        stall_pipeline
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, DONE} state_t;

    state_t      state, state_n;
    logic [15:0] ptr_reg;
    logic [15:0] load_q;
    logic [15:0] byte_data;
    logic        op;
    logic        indirect;
    logic        word_acc1;

    assign op        = mem_valid & (mem_read | mem_write);
    assign indirect  = is_ldi | is_sti;
    assign word_acc1 = indirect | ~is_ldb_stb;
    assign byte_data = mem_addr[0] ? {8'h00, dmem_rdata[15:8]}
                                   : {8'h00, dmem_rdata[7:0]};
    assign load_data = load_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            ptr_reg <= '0;
            load_q  <= '0;
        end else begin
            state <= state_n;
            if (state == ACC1 && dmem_resp) begin
                if (indirect)
                    ptr_reg <= dmem_rdata;
                else if (mem_read)
                    load_q <= is_ldb_stb ? byte_data : dmem_rdata;
            end
            if (state == ACC2 && dmem_resp && is_ldi)
                load_q <= dmem_rdata;
        end
    end

    always_comb begin
        state_n          = state;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = '0;
        dmem_wdata       = '0;
        dmem_byte_enable = 2'b00;
        mem_done         = 1'b0;
        stall_pipeline   = 1'b0;
        unique case (state)
            IDLE: begin
                stall_pipeline = op | stall_other;
                if (op)
                    state_n = ACC1;
            end
            ACC1: begin
                stall_pipeline = 1'b1;
                dmem_read      = mem_read | is_sti;
                dmem_write     = mem_write & ~is_sti;
                if (word_acc1) begin
                    dmem_address     = {mem_addr[15:1], 1'b0};
                    dmem_byte_enable = 2'b11;
                end else begin
                    dmem_address     = mem_addr;
                    dmem_byte_enable = mem_addr[0] ? 2'b10 : 2'b01;
                end
                // Byte stores replicate the byte onto both lanes
                if (mem_write & ~is_sti)
                    dmem_wdata = word_acc1 ? mem_wdata
                                           : {mem_wdata[7:0], mem_wdata[7:0]};
                if (dmem_resp)
                    state_n = indirect ? ACC2 : DONE;
            end
            ACC2: begin
                stall_pipeline   = 1'b1;
                dmem_address     = {ptr_reg[15:1], 1'b0};
                dmem_byte_enable = 2'b11;
                dmem_read        = is_ldi;
                dmem_write       = is_sti;
                if (is_sti)
                    dmem_wdata = mem_wdata;
                if (dmem_resp)
                    state_n = DONE;
            end
            DONE: begin
                mem_done       = 1'b1;
                stall_pipeline = stall_other;
                if (!stall_other)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef MEM_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!reset_n)
            cnt_q <= '0;
        else if (stall_cnt_clr)
            cnt_q <= '0;
        else if ((state == ACC1 || state == ACC2) && cnt_q != '1)
            cnt_q <= cnt_q + 1'b1;
    end

    assign stall_cycles = cnt_q;
`endif

endmodule

// File: tb/tb_mem_stage_sequencer.sv
// Self-checking bench for mem_stage_sequencer: directed scenarios plus random ops
// against a transaction-level reference model.
module tb_mem_stage_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_valid, mem_read, mem_write;
    logic        is_ldi, is_sti, is_ldb_stb;
    logic [15:0] mem_addr, mem_wdata;
    logic        stall_other;
    logic        dmem_resp;
    logic [15:0] dmem_rdata;
    logic        dmem_read, dmem_write;
    logic [15:0] dmem_address, dmem_wdata;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] load_data;
    logic        mem_done;
    logic        stall_pipeline;
    logic        stall_cnt_clr;
`ifdef MEM_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int errors = 0;
    int checks = 0;
    logic [15:0] model_load;

    mem_stage_sequencer #(.STALL_CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
        .is_ldi(is_ldi), .is_sti(is_sti), .is_ldb_stb(is_ldb_stb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .stall_other(stall_other),
        .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
        .dmem_byte_enable(dmem_byte_enable),
        .load_data(load_data), .mem_done(mem_done),
`ifdef MEM_STALL_CNT_EN
        .stall_cnt_clr(stall_cnt_clr), .stall_cycles(stall_cycles),
`endif
        .stall_pipeline(stall_pipeline)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        mem_valid = 0; mem_read = 0; mem_write = 0;
        is_ldi = 0; is_sti = 0; is_ldb_stb = 0;
        mem_addr = 0; mem_wdata = 0; stall_other = 0;
        dmem_resp = 0; dmem_rdata = 0; stall_cnt_clr = 0;
    endtask

    // kind: 0 LDR, 1 LDB, 2 STR, 3 STB, 4 LDI, 5 STI
    task automatic run_op(input int kind, input logic [15:0] addr,
                          input logic [15:0] wdata, input int w1, input int w2,
                          input int hold, input logic [15:0] r1,
                          input logic [15:0] r2);
        logic rd, wr, ldi, sti, byt, ind;
        logic e_rd, e_wr;
        logic [15:0] e_ad, e_wd;
        logic [1:0] e_be;
        int nacc, nwait;
        rd  = (kind == 0 || kind == 1 || kind == 4);
        wr  = (kind == 2 || kind == 3 || kind == 5);
        ldi = (kind == 4);
        sti = (kind == 5);
        byt = (kind == 1 || kind == 3);
        ind = ldi | sti;
        mem_valid = 1; mem_read = rd; mem_write = wr;
        is_ldi = ldi; is_sti = sti; is_ldb_stb = byt;
        mem_addr = addr; mem_wdata = wdata; stall_other = 0;
        #1;
        checks++;
        if ({stall_pipeline, dmem_read, dmem_write, mem_done} !== 4'b1000) begin
            errors++;
            $display("FAIL idle_stall kind=%0d got=%b exp=1000", kind,
                     {stall_pipeline, dmem_read, dmem_write, mem_done});
        end
        nacc = ind ? 2 : 1;
        for (int a = 0; a < nacc; a++) begin
            nwait = (a == 0) ? w1 : w2;
            for (int k = 0; k <= nwait; k++) begin
                @(negedge clk);
                if (a == 0) begin
                    e_rd = rd | sti;
                    e_wr = wr & ~sti;
                    e_ad = (ind | ~byt) ? {addr[15:1], 1'b0} : addr;
                    e_be = (byt & ~ind) ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
                    e_wd = (byt & ~ind) ? {wdata[7:0], wdata[7:0]} : wdata;
                end else begin
                    e_rd = ldi;
                    e_wr = sti;
                    e_ad = {r1[15:1], 1'b0};
                    e_be = 2'b11;
                    e_wd = wdata;
                end
                checks++;
                if ({dmem_read, dmem_write, dmem_address, stall_pipeline, mem_done}
                    !== {e_rd, e_wr, e_ad, 1'b1, 1'b0}) begin
                    errors++;
                    $display("FAIL acc_ctl kind=%0d acc=%0d got=%b_%b_%h_%b_%b exp=%b_%b_%h_1_0",
                             kind, a, dmem_read, dmem_write, dmem_address,
                             stall_pipeline, mem_done, e_rd, e_wr, e_ad);
                end
                if (e_wr) begin
                    checks++;
                    if (dmem_wdata !== e_wd) begin
                        errors++;
                        $display("FAIL acc_wdata kind=%0d got=%h exp=%h", kind, dmem_wdata, e_wd);
                    end
                end
                if (!(a == 0 && byt && rd)) begin
                    checks++;
                    if (dmem_byte_enable !== e_be) begin
                        errors++;
                        $display("FAIL acc_be kind=%0d got=%b exp=%b", kind, dmem_byte_enable, e_be);
                    end
                end
                if (k == nwait) begin
                    dmem_resp = 1;
                    dmem_rdata = (a == 0) ? r1 : r2;
                end else begin
                    dmem_resp = 0;
                    dmem_rdata = 16'($urandom);
                end
            end
        end
        if (ldi)
            model_load = r2;
        else if (rd)
            model_load = byt ? (addr[0] ? {8'h00, r1[15:8]} : {8'h00, r1[7:0]}) : r1;
        @(negedge clk);
        dmem_resp = 0;
        dmem_rdata = 16'($urandom);
        checks++;
        if ({mem_done, stall_pipeline, dmem_read, dmem_write, load_data}
            !== {4'b1000, model_load}) begin
            errors++;
            $display("FAIL done kind=%0d got=%b%b%b%b_%h exp=1000_%h", kind, mem_done,
                     stall_pipeline, dmem_read, dmem_write, load_data, model_load);
        end
        if (hold > 0) begin
            stall_other = 1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                checks++;
                if ({mem_done, stall_pipeline, load_data} !== {2'b11, model_load}) begin
                    errors++;
                    $display("FAIL done_hold kind=%0d got=%b%b_%h exp=11_%h", kind,
                             mem_done, stall_pipeline, load_data, model_load);
                end
            end
            stall_other = 0;
        end
        mem_valid = 0; mem_read = 0; mem_write = 0;
        is_ldi = 0; is_sti = 0; is_ldb_stb = 0;
        @(negedge clk);
        checks++;
        if ({mem_done, stall_pipeline, load_data} !== {2'b00, model_load}) begin
            errors++;
            $display("FAIL retire kind=%0d got=%b%b_%h exp=00_%h", kind,
                     mem_done, stall_pipeline, load_data, model_load);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset_n = 0;
        repeat (3) @(negedge clk);
        checks++;
        if ({dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
             load_data, mem_done, stall_pipeline} !== '0) begin
            errors++;
            $display("FAIL reset got=%b%b_%h_%h_%b_%h_%b%b exp=all zero", dmem_read,
                     dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
                     load_data, mem_done, stall_pipeline);
        end
        reset_n = 1;
        model_load = 16'h0000;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(0, 16'h3005, 16'h0000, 3, 0, 0, 16'hBEEF, 16'h0000);
        run_op(3, 16'h4001, 16'h12A5, 1, 0, 0, 16'h0000, 16'h0000);
        run_op(4, 16'h2000, 16'h0000, 1, 2, 0, 16'h5002, 16'h7777);
        run_op(5, 16'h2100, 16'h0F0F, 0, 1, 0, 16'h6001, 16'h0000);
        run_op(1, 16'h1235, 16'h0000, 0, 0, 0, 16'hAB34, 16'h0000);
        run_op(1, 16'h1234, 16'h0000, 2, 0, 0, 16'hAB34, 16'h0000);
        run_op(3, 16'h4000, 16'h12A5, 0, 0, 0, 16'h0000, 16'h0000);
    endtask

    task automatic test_stall_other();
        run_op(0, 16'h0102, 16'h0000, 1, 0, 2, 16'hC0DE, 16'h0000);
        run_op(4, 16'h0200, 16'h0000, 0, 0, 1, 16'h0400, 16'h9999);
    endtask

    task automatic test_no_op();
        logic so;
        for (int i = 0; i < 6; i++) begin
            so = 1'($urandom);
            mem_valid = (i % 2 == 0);
            mem_read  = (i % 2 == 1);
            mem_write = 0;
            stall_other = so;
            @(negedge clk);
            checks++;
            if ({stall_pipeline, mem_done, dmem_read, dmem_write} !== {so, 3'b000}) begin
                errors++;
                $display("FAIL no_op i=%0d got=%b exp=%b000", i,
                         {stall_pipeline, mem_done, dmem_read, dmem_write}, so);
            end
        end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen;
        mem_valid = 1; mem_read = 1; is_ldi = 1; mem_addr = 16'h2000;
        @(negedge clk);
        dmem_resp = 1; dmem_rdata = 16'h5002;
        @(negedge clk);
        dmem_resp = 0;
        checks++;
        if ({dmem_read, dmem_address} !== {1'b1, 16'h5002}) begin
            errors++;
            $display("FAIL mid_acc2 got=%b_%h exp=1_5002", dmem_read, dmem_address);
        end
        reset_n = 0;
        clear_inputs();
        dmem_resp = 1; dmem_rdata = 16'h7777;
        @(negedge clk);
        checks++;
        if ({dmem_read, dmem_write, dmem_address, mem_done, stall_pipeline} !== '0) begin
            errors++;
            $display("FAIL mid_reset got=%b%b_%h_%b%b exp=00_0000_00", dmem_read,
                     dmem_write, dmem_address, mem_done, stall_pipeline);
        end
        reset_n = 1;
        dmem_resp = 0;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (mem_done === 1'b1) seen++;
        end
        model_load = 16'h0000;
        checks++;
        if (seen != 0 || load_data !== model_load) begin
            errors++;
            $display("FAIL mid_after done_seen=%0d load=%h exp=0_%h", seen, load_data, model_load);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++)
            run_op($urandom_range(0, 5), 16'($urandom), 16'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                   16'($urandom), 16'($urandom));
    endtask

`ifdef MEM_STALL_CNT_EN
    task automatic test_stall_cnt();
        stall_cnt_clr = 1;
        @(negedge clk);
        stall_cnt_clr = 0;
        checks++;
        if (stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL cnt_clr0 got=%0d exp=0", stall_cycles);
        end
        for (int i = 0; i < 3; i++)
            run_op(0, 16'($urandom), 16'h0000, 2, 0, 0, 16'($urandom), 16'h0000);
        checks++;
        if (stall_cycles !== 16'd9) begin
            errors++;
            $display("FAIL cnt_three got=%0d exp=9", stall_cycles);
        end
        stall_cnt_clr = 1;
        @(negedge clk);
        stall_cnt_clr = 0;
        checks++;
        if (stall_cycles !== 16'd0) begin
            errors++;
            $display("FAIL cnt_clr got=%0d exp=0", stall_cycles);
        end
    endtask
`endif

    initial begin
        clear_inputs();
        reset_n = 0;
        model_load = 0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_stall_other();
        test_no_op();
        test_reset_mid();
        test_random();
`ifdef MEM_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
